// File: rtl/rv32i_types.sv
// Shared RV32I load-path types: reservation-station entry, branch tag, CDB payload,
// load funct3 encodings, plus squash-match and byte-mask helpers.
package rv32i_types;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ROB_W = 3;
    localparam int unsigned TAG_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic             sign;
        logic [TAG_W-1:0] tag;
    } branch_tag_t;

    typedef struct packed {
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  imm;
        logic [2:0]       funct3;
        logic [ROB_W-1:0] rob_idx;
        branch_tag_t      br_tag;
    } ResEntryLd_reg_t;

    typedef struct packed {
        logic             commit_valid;
        logic [ROB_W-1:0] dest_ROB;
        logic [XLEN-1:0]  rd_v;
    } CDB_output_t;

    // True when an instruction tagged br lies on the mispredicted path named by fl.
    function automatic logic squash_match(input branch_tag_t br, input branch_tag_t fl);
        if (br.sign == fl.sign) begin
            return (br.tag & fl.tag) == fl.tag;
        end
        return (br.tag & fl.tag) == br.tag;
    endfunction

    // Byte lanes touched by a load; a misaligned LH can shift its upper lane out.
    function automatic logic [3:0] load_rmask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data formatting: lane shift plus sign/zero extension by funct3.
module load_align
    import rv32i_types::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (funct3_i[1:0])
            2'b00:   data_o = funct3_i[2] ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   data_o = funct3_i[2] ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load functional unit: address generation, one memory request,
// response formatting and CDB broadcast, with branch-tag squash at every stage.
module load_unit
    import rv32i_types::*;
#(
    parameter int unsigned ROB_WIDTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  ResEntryLd_reg_t entry_in,
    output logic            FU_running,
    input  logic            flush,
    input  branch_tag_t     flush_tag,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_rmask,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output logic            cdb_req,
    input  logic            cdb_grant,
    output CDB_output_t     CDB_value
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_BCAST} state_t;

    state_t                 state_q, state_d;
    logic                   squashed_q, squashed_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [ROB_WIDTH-1:0]   rob_q, rob_d;
    branch_tag_t            tag_q, tag_d;
    logic [XLEN-1:0]        data_q, data_d;
    logic [XLEN-1:0]        aligned;
    logic                   commit;
    logic                   flush_hit;
    logic                   issue_hit;

    load_align u_align (
        .rdata_i  (dmem_rdata),
        .offset_i (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (aligned)
    );

    assign flush_hit = flush && squash_match(tag_q, flush_tag);
    assign issue_hit = flush && squash_match(entry_in.br_tag, flush_tag);

    always_comb begin
        state_d    = state_q;
        squashed_d = squashed_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        rob_d      = rob_q;
        tag_d      = tag_q;
        data_d     = data_q;
        dmem_rmask = 4'b0000;
        cdb_req    = 1'b0;
        commit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue && !issue_hit) begin
                    addr_d   = entry_in.rs1_data + entry_in.imm;
                    funct3_d = entry_in.funct3;
                    rob_d    = ROB_WIDTH'(entry_in.rob_idx);
                    tag_d    = entry_in.br_tag;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_hit) begin
                    state_d = S_IDLE;
                end else begin
                    dmem_rmask = load_rmask(funct3_q, addr_q[1:0]);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // A squashed load still drains its response so memory stays in sync.
                if (flush_hit) squashed_d = 1'b1;
                if (dmem_resp) begin
                    if (squashed_q || flush_hit) begin
                        squashed_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        data_d  = aligned;
                        state_d = S_BCAST;
                    end
                end
            end
            S_BCAST: begin
                if (flush_hit) begin
                    state_d = S_IDLE;
                end else begin
                    cdb_req = 1'b1;
                    commit  = cdb_grant;
                    if (cdb_grant) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            squashed_q <= 1'b0;
            addr_q     <= '0;
            funct3_q   <= '0;
            rob_q      <= '0;
            tag_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            squashed_q <= squashed_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            rob_q      <= rob_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
        end
    end

    assign FU_running = (state_q != S_IDLE);
    assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};

    always_comb begin
        CDB_value              = '0;
        CDB_value.commit_valid = commit;
        CDB_value.dest_ROB     = ROB_W'(rob_q);
        CDB_value.rd_v         = data_q;
    end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: vector table for formatting/latency plus
// hand sequences for stall, squash and reset corners; commits checked by scoreboard.
module tb_load_unit;
    import rv32i_types::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue;
    ResEntryLd_reg_t entry_in;
    logic            FU_running;
    logic            flush;
    branch_tag_t     flush_tag;
    logic [31:0]     dmem_addr;
    logic [3:0]      dmem_rmask;
    logic [31:0]     dmem_rdata;
    logic            dmem_resp;
    logic            cdb_req;
    logic            cdb_grant;
    CDB_output_t     CDB_value;

    load_unit #(.ROB_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .issue(issue), .entry_in(entry_in), .FU_running(FU_running),
        .flush(flush), .flush_tag(flush_tag), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .cdb_req(cdb_req),
        .cdb_grant(cdb_grant), .CDB_value(CDB_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_rd;
        logic        rd_dc;
        int          gdelay;
    } vec_t;

    typedef struct {
        logic [2:0]  rob;
        logic [31:0] rd;
        logic        rd_dc;
    } exp_t;

    exp_t sbq[$];
    int   nchecks = 0;
    int   nerr    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Commit monitor: every commit_valid must match the oldest expected load.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (CDB_value.commit_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL unexpected_commit: got dest %0d rd %h, required no commit",
                         CDB_value.dest_ROB, CDB_value.rd_v);
            end else begin
                e = sbq.pop_front();
                chk("cdb_dest", 32'(CDB_value.dest_ROB), 32'(e.rob));
                if (!e.rd_dc) chk("cdb_rd_v", CDB_value.rd_v, e.rd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic issue_one(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [2:0] rob, input branch_tag_t bt);
        entry_in = '{rs1_data: addr, imm: 32'h0, funct3: f3, rob_idx: rob, br_tag: bt};
        issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
    endtask

    vec_t        vecs[10];
    branch_tag_t bt;

    initial begin
        rst = 1'b1; issue = 1'b0; entry_in = '0; flush = 1'b0; flush_tag = '0;
        dmem_rdata = '0; dmem_resp = 1'b0; cdb_grant = 1'b0;

        vecs[0] = '{F3_LW,  32'h0000_1000, 32'h4,         32'hDEAD_BEEF, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 1'b0, 0};
        vecs[1] = '{F3_LB,  32'h0000_1000, 32'h3,         32'h80FF_FFFF, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80, 1'b0, 3};
        vecs[2] = '{F3_LBU, 32'h0000_1000, 32'h3,         32'h80FF_FFFF, 32'h0000_1000, 4'b1000, 32'h0000_0080, 1'b0, 0};
        vecs[3] = '{F3_LHU, 32'h0000_1000, 32'h2,         32'hBEEF_0000, 32'h0000_1000, 4'b1100, 32'h0000_BEEF, 1'b0, 1};
        vecs[4] = '{F3_LH,  32'h0000_2000, 32'hFFFF_FFFE, 32'h8001_1234, 32'h0000_1FFC, 4'b1100, 32'hFFFF_8001, 1'b0, 0};
        vecs[5] = '{F3_LB,  32'h0000_0000, 32'h0,         32'h1234_567F, 32'h0000_0000, 4'b0001, 32'h0000_007F, 1'b0, 0};
        vecs[6] = '{F3_LH,  32'hFFFF_FFFE, 32'h4,         32'h7FFF_0000, 32'h0000_0000, 4'b1100, 32'h0000_7FFF, 1'b0, 0};
        vecs[7] = '{F3_LBU, 32'h0000_3001, 32'h0,         32'h0000_AB00, 32'h0000_3000, 4'b0010, 32'h0000_00AB, 1'b0, 2};
        vecs[8] = '{F3_LH,  32'h0000_0010, 32'h0,         32'h1234_F00D, 32'h0000_0010, 4'b0011, 32'hFFFF_F00D, 1'b0, 0};
        vecs[9] = '{F3_LW,  32'h0000_1001, 32'h0,         32'h1111_2222, 32'h0000_1000, 4'b1111, 32'h0,         1'b1, 0};

        #2 rst = 1'b0;
        #1;
        chk("rst_fu_running", 32'(FU_running), 32'd0);
        chk("rst_cdb_req",    32'(cdb_req),    32'd0);
        chk("rst_commit",     32'(CDB_value.commit_valid), 32'd0);
        chk("rst_rmask",      32'(dmem_rmask), 32'd0);
        chk("rst_rd_v",       CDB_value.rd_v,  32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven loads: request shape, formatting, latency, grant stalls.
        for (int i = 0; i < 10; i++) begin
            entry_in = '{rs1_data: vecs[i].base, imm: vecs[i].imm, funct3: vecs[i].f3,
                         rob_idx: 3'(i), br_tag: '{sign: 1'b0, tag: 4'b0001}};
            issue = 1'b1;
            sbq.push_back('{rob: 3'(i), rd: vecs[i].exp_rd, rd_dc: vecs[i].rd_dc});
            #1 chk("issue_idle", 32'(FU_running), 32'd0);
            @(negedge clk);
            issue = 1'b0;
            #1;
            chk("req_addr", dmem_addr, vecs[i].exp_addr);
            chk("req_rmask", 32'(dmem_rmask), 32'(vecs[i].exp_mask));
            chk("req_busy", 32'(FU_running), 32'd1);
            chk("req_cdb_req", 32'(cdb_req), 32'd0);
            @(negedge clk);
            #1 chk("wait_rmask", 32'(dmem_rmask), 32'd0);
            dmem_resp = 1'b1; dmem_rdata = vecs[i].rdata;
            @(negedge clk);
            dmem_resp = 1'b0; dmem_rdata = $urandom;
            for (int k = 0; k < vecs[i].gdelay; k++) begin
                cdb_grant = 1'b0;
                issue = 1'b1;
                #1;
                chk("stall_cdb_req", 32'(cdb_req), 32'd1);
                chk("stall_commit", 32'(CDB_value.commit_valid), 32'd0);
                chk("stall_dest", 32'(CDB_value.dest_ROB), 32'(i));
                if (!vecs[i].rd_dc) chk("stall_rd_v", CDB_value.rd_v, vecs[i].exp_rd);
                @(negedge clk);
            end
            issue = 1'b0;
            cdb_grant = 1'b1;
            #1 chk("bcast_cdb_req", 32'(cdb_req), 32'd1);
            @(negedge clk);
            cdb_grant = 1'b0;
            #1;
            chk("post_idle", 32'(FU_running), 32'd0);
            chk("post_rmask", 32'(dmem_rmask), 32'd0);
            @(negedge clk);
        end

        // Matching flush in REQ: request suppressed, back to IDLE.
        bt = '{sign: 1'b0, tag: 4'b0011};
        issue_one(F3_LW, 32'h4000, 3'd1, bt);
        flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 4'b0001};
        #1 chk("reqflush_rmask", 32'(dmem_rmask), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("reqflush_idle", 32'(FU_running), 32'd0);
        @(negedge clk);

        // Matching flush in WAIT (sign-differ rule); response two cycles later, no broadcast.
        cdb_grant = 1'b1;
        bt = '{sign: 1'b0, tag: 4'b0001};
        issue_one(F3_LW, 32'h4000, 3'd2, bt);
        @(negedge clk);
        flush = 1'b1; flush_tag = '{sign: 1'b1, tag: 4'b0011};
        @(negedge clk);
        flush = 1'b0;
        #1 chk("waitflush_hold", 32'(FU_running), 32'd1);
        @(negedge clk);
        dmem_resp = 1'b1; dmem_rdata = 32'h5555_AAAA;
        #1 chk("waitflush_no_req", 32'(cdb_req), 32'd0);
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        chk("waitflush_idle", 32'(FU_running), 32'd0);
        chk("waitflush_cdb_req", 32'(cdb_req), 32'd0);
        @(negedge clk);
        cdb_grant = 1'b0;

        // Non-matching flush at the same point: normal broadcast.
        issue_one(F3_LW, 32'h4008, 3'd3, bt);
        sbq.push_back('{rob: 3'd3, rd: 32'hCAFE_F00D, rd_dc: 1'b0});
        @(negedge clk);
        flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 4'b0010};
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_resp = 1'b0;
        #1 chk("nomatch_cdb_req", 32'(cdb_req), 32'd1);
        cdb_grant = 1'b1;
        @(negedge clk);
        cdb_grant = 1'b0;
        #1 chk("nomatch_idle", 32'(FU_running), 32'd0);
        @(negedge clk);

        // Matching flush coincident with grant in BCAST.
        bt = '{sign: 1'b0, tag: 4'b0100};
        issue_one(F3_LW, 32'h4010, 3'd4, bt);
        @(negedge clk);
        dmem_resp = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        dmem_resp = 1'b0;
        flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 4'b0100};
        cdb_grant = 1'b1;
        #1;
        chk("bcflush_commit", 32'(CDB_value.commit_valid), 32'd0);
        chk("bcflush_cdb_req", 32'(cdb_req), 32'd0);
        @(negedge clk);
        flush = 1'b0; cdb_grant = 1'b0;
        #1 chk("bcflush_idle", 32'(FU_running), 32'd0);
        @(negedge clk);

        // Matching flush alongside issue in IDLE: entry refused.
        entry_in = '{rs1_data: 32'h5000, imm: 32'h0, funct3: F3_LW, rob_idx: 3'd6,
                     br_tag: '{sign: 1'b0, tag: 4'b0110}};
        issue = 1'b1; flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 4'b0010};
        @(negedge clk);
        issue = 1'b0; flush = 1'b0;
        #1;
        chk("idleflush_idle", 32'(FU_running), 32'd0);
        chk("idleflush_rmask", 32'(dmem_rmask), 32'd0);
        @(negedge clk);

        // Reset mid-WAIT, then a stray response in IDLE.
        bt = '{sign: 1'b0, tag: 4'b0001};
        issue_one(F3_LW, 32'h4020, 3'd5, bt);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_fu", 32'(FU_running), 32'd0);
        chk("midrst_cdb_req", 32'(cdb_req), 32'd0);
        chk("midrst_rmask", 32'(dmem_rmask), 32'd0);
        chk("midrst_rd_v", CDB_value.rd_v, 32'd0);
        chk("midrst_dest", 32'(CDB_value.dest_ROB), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777; cdb_grant = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        chk("stray_fu", 32'(FU_running), 32'd0);
        chk("stray_cdb_req", 32'(cdb_req), 32'd0);
        @(negedge clk);
        cdb_grant = 1'b0;
        @(negedge clk);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 3, width of ROB index on CDB.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous active-low reset; both single-clock, no other clock.
REQ-003 SHALL have ports: issue  in  1  RS issue strobe; entry_in  in  ResEntryLd_reg_t  issued load (rs1_data base, imm, funct3, rob_idx, br_tag).
REQ-004 SHALL have port: FU_running  out  1  unit busy, RS holds issue.
REQ-005 SHALL have ports: flush  in  1  mispredict; flush_tag  in  branch_tag_t  squash tag.
REQ-006 SHALL have ports: dmem_addr  out  32  word-aligned address; dmem_rmask  out  4  byte read mask; dmem_rdata  in  32; dmem_resp  in  1  response valid.
REQ-007 SHALL have ports: cdb_req  out  1  broadcast request; cdb_grant  in  1  arbiter grant; CDB_value  out  CDB_output_t  (commit_valid, dest_ROB, rd_v).

Function
REQ-008 SHALL implement FSM IDLE, REQ, WAIT, BCAST; FU_running = (state != IDLE).
REQ-009 IDLE: issue=1 latches entry_in, computes addr = rs1_data + imm (mod 2^32), next REQ; issue ignored in any other state.
REQ-010 REQ: drive dmem_addr = {addr[31:2],2'b00}, dmem_rmask per funct3/addr[1:0] (LB/LBU 4'b0001<<a, LH/LHU 4'b0011<<a, LW 4'b1111) for exactly one cycle, next WAIT; dmem_rmask = 0 in all other states.
REQ-011 WAIT: hold until dmem_resp=1; capture dmem_rdata shifted right by 8*addr[1:0], sign- (LB/LH) or zero-extended (LBU/LHU) to 32 bits; next BCAST.
REQ-012 BCAST: cdb_req=1, CDB_value.dest_ROB = rob_idx, rd_v = formatted data; commit_valid = cdb_grant; on grant next IDLE, else hold all fields stable.
REQ-013 Minimum latency: issue cycle N, request N+1, response N+2, broadcast N+3 with grant; new issue accepted N+4.
REQ-014 Misaligned LH (addr[0]=1) or LW (addr[1:0]!=0): rd_v undefined, FSM SHALL still complete, never hang.
REQ-015 Squash match: (br_tag.sign == flush_tag.sign and (br_tag.tag & flush_tag.tag) == flush_tag.tag) or (sign differ and (br_tag.tag & flush_tag.tag) == br_tag.tag).
REQ-016 Flush matching in IDLE-with-issue: entry not accepted, stay IDLE.
REQ-017 Flush matching in REQ: request suppressed (rmask 0), return IDLE.
REQ-018 Flush matching in WAIT: set squashed flag, remain WAIT until dmem_resp, then IDLE without BCAST.
REQ-019 Flush matching in BCAST: commit_valid forced 0 that cycle, cdb_req dropped, next IDLE; flush overrides simultaneous grant.
REQ-020 Non-matching flush SHALL have no effect.
REQ-021 cdb_req and commit_valid SHALL be 0 outside BCAST.

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE, squashed=0, FU_running=0, cdb_req=0, commit_valid=0, dmem_rmask=0, latched entry cleared.
REQ-023 Reset mid-WAIT SHALL abandon the outstanding response; a dmem_resp arriving in IDLE SHALL be ignored.

Structure
REQ-024 ResEntryLd_reg_t, branch_tag_t, CDB_output_t, load funct3 encodings SHALL live in rv32i_types.
REQ-025 FSM state enum SHALL be local to the module.
REQ-026 Data formatting (shift, extend) SHALL be sub-module load_align, purely combinational.

Verification
REQ-027 LW base 0x1000 imm 4, rdata 0xDEADBEEF, resp N+2, grant N+3 -> dmem_addr 0x1004, rmask 1111, rd_v 0xDEADBEEF at N+3, FU_running low N+4.
REQ-028 LB addr 0x1003, rdata 0x80FF_FFFF -> rmask 1000, rd_v 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x1002 rdata 0xBEEF0000 -> rmask 1100, rd_v 0x0000BEEF.
REQ-029 Grant withheld 3 cycles in BCAST -> cdb_req high, CDB_value stable, commit_valid only on grant cycle, issue during stall ignored.
REQ-030 Matching flush in WAIT, resp 2 cycles later -> no commit_valid, IDLE after resp; non-matching flush same point -> normal broadcast.
REQ-031 Matching flush coincident with grant in BCAST -> commit_valid 0, IDLE next cycle.
REQ-032 rst low mid-WAIT, then late dmem_resp -> all outputs reset immediately, stray resp causes no broadcast.
